// File: rtl/athos_pkg.sv
// athos_pkg: shared Kyber constants and types for the athos polynomial datapath.
//   KYBER_N / KYBER_Q : polynomial length and modulus
//   coeff_t           : 16-bit coefficient container (12 significant bits)
//   coeff_pair_t      : payload of one unpacked coefficient pair
//   byte_phase_e      : position of the next byte inside a 3-byte group
`timescale 1ns/1ps
package athos_pkg;

   localparam int unsigned KYBER_N  = 256;
   localparam int unsigned KYBER_Q  = 3329;
   localparam int unsigned COEFF_W  = 16;
   localparam int unsigned PACKED_W = 12;
   localparam int unsigned BYTE_W   = 8;

   typedef logic [COEFF_W-1:0] coeff_t;

   typedef struct packed {
      coeff_t     coeff0;
      coeff_t     coeff1;
      logic [1:0] geq_q;
      logic       last;
   } coeff_pair_t;

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2
   } byte_phase_e;

   // Zero-extend a packed 12-bit value into the coefficient container.
   function automatic coeff_t zext_coeff(input logic [PACKED_W-1:0] v);
      return coeff_t'(v);
   endfunction

endpackage

// File: rtl/poly_frombytes_unpack.sv
// poly_frombytes_unpack: combinational 3-byte -> 2-coefficient unpack.
//   i_b0, i_b1, i_b2 : bytes of one group, Kyber encoding order
//   o_coeff0         : {b1[3:0], b0}, zero-extended
//   o_coeff1         : {b2, b1[7:4]}, zero-extended
//   o_geq_q          : bit i set when o_coeffi >= Q
`timescale 1ns/1ps
module poly_frombytes_unpack
   import athos_pkg::*;
#(
   parameter int unsigned Q = KYBER_Q
) (
   input  logic [BYTE_W-1:0] i_b0,
   input  logic [BYTE_W-1:0] i_b1,
   input  logic [BYTE_W-1:0] i_b2,
   output coeff_t            o_coeff0,
   output coeff_t            o_coeff1,
   output logic [1:0]        o_geq_q
);

   logic [PACKED_W-1:0] w_c0;
   logic [PACKED_W-1:0] w_c1;

   // Low nibble of b1 extends coeff0, high nibble starts coeff1.
   assign w_c0 = {i_b1[3:0], i_b0};
   assign w_c1 = {i_b2, i_b1[7:4]};

   assign o_coeff0 = zext_coeff(w_c0);
   assign o_coeff1 = zext_coeff(w_c1);

   assign o_geq_q[0] = (o_coeff0 >= coeff_t'(Q));
   assign o_geq_q[1] = (o_coeff1 >= coeff_t'(Q));

endmodule

// File: rtl/poly_frombytes_stream.sv
// poly_frombytes_stream: streaming byte -> coefficient-pair unpacker.
//   clk_i, rst_ni (sync, active-low), clear_i (sync soft clear)
//   in_valid_i / in_ready_o / in_byte_i          : byte stream input
//   out_valid_o / out_ready_i                     : coefficient pair output
//   out_coeff0_o, out_coeff1_o, out_geq_q_o       : pair payload and range flags
//   out_last_o                                    : final pair of the polynomial
//   busy_o                                        : partial polynomial or pending pair
`timescale 1ns/1ps
module poly_frombytes_stream
   import athos_pkg::*;
#(
   parameter int unsigned N_COEFF = KYBER_N,
   parameter int unsigned Q       = KYBER_Q
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [BYTE_W-1:0] in_byte_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [15:0]       out_coeff0_o,
   output logic [15:0]       out_coeff1_o,
   output logic [1:0]        out_geq_q_o,
   output logic              out_last_o,
   output logic              busy_o
);

   localparam int unsigned PAIRS  = N_COEFF / 2;
   localparam int unsigned PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIRS - 1);

   byte_phase_e         r_phase;
   logic [BYTE_W-1:0]   r_b0;
   logic [BYTE_W-1:0]   r_b1;
   logic [PAIR_W-1:0]   r_pair_cnt;
   logic                r_out_valid;
   coeff_pair_t         r_out;

   coeff_t              w_coeff0;
   coeff_t              w_coeff1;
   logic [1:0]          w_geq_q;
   logic                w_in_hs;
   logic                w_out_hs;
   logic [PAIR_W-1:0]   w_cnt_next;
   logic [PAIR_W-1:0]   w_cnt_at_load;

   poly_frombytes_unpack #(
      .Q (Q)
   ) u_unpack (
      .i_b0     (r_b0),
      .i_b1     (r_b1),
      .i_b2     (in_byte_i),
      .o_coeff0 (w_coeff0),
      .o_coeff1 (w_coeff1),
      .o_geq_q  (w_geq_q)
   );

   // Byte 2 may only land when the output register is free or draining now.
   assign in_ready_o = rst_ni && !clear_i &&
                       ((r_phase != B2) || !r_out_valid || out_ready_i);

   assign w_in_hs  = in_valid_i && in_ready_o;
   assign w_out_hs = r_out_valid && out_ready_i;

   assign w_cnt_next = (r_pair_cnt == LAST_PAIR) ? '0 : (r_pair_cnt + PAIR_W'(1));

   // Index of a pair loaded this cycle: a same-cycle drain advances the count first.
   assign w_cnt_at_load = w_out_hs ? w_cnt_next : r_pair_cnt;

   // Phase FSM, staging bytes, pair counter and output register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_phase     <= B0;
         r_b0        <= '0;
         r_b1        <= '0;
         r_pair_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else begin
         if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_pair_cnt  <= w_cnt_next;
         end
         if (w_in_hs) begin
            case (r_phase)
               B0: begin
                  r_b0    <= in_byte_i;
                  r_phase <= B1;
               end
               B1: begin
                  r_b1    <= in_byte_i;
                  r_phase <= B2;
               end
               B2: begin
                  // Overrides the drain above when both happen together.
                  r_out_valid  <= 1'b1;
                  r_out.coeff0 <= w_coeff0;
                  r_out.coeff1 <= w_coeff1;
                  r_out.geq_q  <= w_geq_q;
                  r_out.last   <= (w_cnt_at_load == LAST_PAIR);
                  r_phase      <= B0;
               end
               default: begin
                  r_phase <= B0;
               end
            endcase
         end
      end
   end

   assign out_valid_o  = r_out_valid;
   assign out_coeff0_o = r_out.coeff0;
   assign out_coeff1_o = r_out.coeff1;
   assign out_geq_q_o  = r_out.geq_q;
   assign out_last_o   = r_out_valid && r_out.last;
   assign busy_o       = (r_phase != B0) || r_out_valid || (r_pair_cnt != '0);

endmodule

// File: doc/poly_frombytes_stream.md
# poly_frombytes_stream

Streaming byte-to-coefficient unpacker for the ML-KEM/Kyber datapath: the inverse of the coefficient-to-byte packing. Consumes a byte stream over a valid/ready handshake, regroups every 3 bytes into two 12-bit coefficients, and emits them as a coefficient pair over a second valid/ready handshake. Counts pairs per polynomial, flags the last pair, and flags coefficients ≥ q (encapsulation-key modulus check). Sits between the memory/bus byte source and the polynomial register file inside the athos accelerator.

## Interface
- N_COEFF, 256, coefficients per polynomial (must be even)
- Q, 3329, modulus used for the range flag
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- clear_i  in  1  synchronous soft clear, same effect as reset
- in_valid_i  in  1  byte valid
- in_ready_o  out  1  byte accepted when in_valid_i && in_ready_o
- in_byte_i  in  8  input byte, Kyber encoding order
- out_valid_o  out  1  coefficient pair valid
- out_ready_i  in  1  pair consumed when out_valid_o && out_ready_i
- out_coeff0_o  out  16  even coefficient, zero-extended 12-bit
- out_coeff1_o  out  16  odd coefficient, zero-extended 12-bit
- out_geq_q_o  out  2  bit i = out_coeffi_o ≥ Q
- out_last_o  out  1  pair is the final pair of the polynomial
- busy_o  out  1  a polynomial is partially received or a pair is pending

## Operation
- Byte phase counter byte_cnt ∈ {0,1,2} (states B0, B1, B2); holds b0, b1 in staging registers.
- Handshake on byte in B0 → store b0, go B1; in B1 → store b1, go B2; in B2 → load output register, go B0.
- Unpack on B2 acceptance with b2 = in_byte_i: coeff0 = {b1[3:0], b0}; coeff1 = {b2, b1[7:4]}; upper 4 bits zero.
- out_geq_q bits computed from unpacked values at load time and registered with them.
- Pair counter pair_cnt 0..N_COEFF/2−1; out_last_o = (pair_cnt == N_COEFF/2−1) while out_valid_o. Counter increments on output handshake; wraps to 0 after the last pair, so the next polynomial starts without a clear.
- in_ready_o = (byte_cnt != 2) || !out_valid_o || out_ready_i: bytes 0 and 1 of the next group accepted while a pair is pending; byte 2 stalls until the output register drains or drains in the same cycle.
- Simultaneous output handshake and B2 acceptance: new pair replaces old, out_valid_o stays 1, pair_cnt increments.
- busy_o = (byte_cnt != 0) || out_valid_o || (pair_cnt != 0).
- clear_i / rst_ni low: byte_cnt=0, pair_cnt=0, out_valid_o=0, staging and output data cleared; pending pair and partial bytes discarded; clear beats any same-cycle handshake.
- in_ready_o forced 0 while rst_ni low or clear_i high.

## Timing
- Reset values: out_valid_o=0, out_coeff0_o=0, out_coeff1_o=0, out_geq_q_o=0, out_last_o=0, busy_o=0; in_ready_o=1 first cycle after reset released.
- Latency: out_valid_o rises the cycle after third byte handshake.
- Throughput: 1 byte/cycle sustained with out_ready_i held 1; one pair every 3 cycles; 384 bytes → 128 pairs.
- out_coeff*, out_geq_q_o, out_last_o stable while out_valid_o && !out_ready_i.
- in_ready_o combinational from registered state and out_ready_i only; no path from in_valid_i.

## Structure
- athos_pkg: KYBER_N=256, KYBER_Q=3329, coeff_t (logic [15:0]), coeff_pair_t struct {coeff0, coeff1, geq_q[1:0], last}.
- One combinational sub-module, poly_frombytes_unpack: three bytes in → two coefficients plus geq_q flags; the rest (counters, staging, output register) in the top.

## Test plan
- Bytes 0x01,0x23,0x45, out_ready_i=1 → one pair: coeff0=0x0301, coeff1=0x0452, geq_q=2'b00, out_valid_o one cycle after 0x45.
- Bytes 0x01,0x0D,0xD0 → coeff0=0x0D01 (3329), coeff1=0x0D00 (3328), geq_q=2'b01; bytes 0xFF,0xFF,0xFF → 0x0FFF,0x0FFF, geq_q=2'b11.
- 384 random bytes, out_ready_i=1 → 128 pairs match reference model; out_last_o only on pair 128; busy_o=0 after; 385th–387th bytes give pair with pair_cnt back at 0.
- out_ready_i=0 after first pair: next two bytes accepted, in_ready_o=0 in B2, output data stable; raise out_ready_i → third byte accepted same cycle, new pair next cycle.
- clear_i after 2 bytes with a pair pending → next cycle out_valid_o=0, busy_o=0; following 3 bytes give pair from those bytes only, pair_cnt restarted.
- rst_ni low mid-polynomial (pair 50, byte phase B1) → all outputs at reset values next edge; in_ready_o=0 during reset.
